// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of one fifo among
// NUM_REQ valid/ready requesters. A grant is held for a burst of up to
// MAX_BURST beats. Each written word is tagged with the id of its source so
// that the read side can demultiplex the words.
//
// Ports
//   clk               clock, all logic on the rising edge
//   rst_n             asynchronous reset, active low
//   req_valid[i]      requester i offers a word
//   req_data          flattened payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready[i]      requester i's word is accepted this cycle
//   fifo_w_en         write enable to the fifo
//   fifo_w_data       {grant_id, payload} to the fifo
//   fifo_full         fifo full flag; no write is issued while it is high
//   fifo_almost_full  fifo almost-full flag; limits a grant to one more beat
//   grant_valid       a requester currently holds the grant
//   grant_id          id of the grant holder (meaningful when grant_valid)
//   wr_count          total words written, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    parameter  int CNT_W      = 16,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_en,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_w_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id,
    output logic [CNT_W-1:0]              wr_count
);

    // Burst counter only has to reach MAX_BURST (the value it takes on the
    // final beat, just before the grant is released).
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [ID_W-1:0]   grant_id_q,  grant_id_d;
    logic [ID_W-1:0]   last_id_q,   last_id_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  wr_count_q,  wr_count_d;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic                  xfer;
    logic [ID_W-1:0]       pick_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester after 'last', wrapping modulo NUM_REQ, so the
    // previous holder is considered last.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]    last
    );
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    assign pick_id = rr_pick(req_valid, last_id_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        wr_count_d  = wr_count_q;
        req_ready   = '0;
        fifo_w_en   = 1'b0;
        fifo_w_data = '0;
        xfer        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d  = pick_id;
                    last_id_d   = pick_id;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end

            BURST: begin
                // Ready does not depend on valid; it only backs off when the
                // fifo cannot take a word, which is what prevents overflow.
                if (!fifo_full) begin
                    req_ready = NUM_REQ'(1) << grant_id_q;
                end
                xfer        = req_valid[grant_id_q] && !fifo_full;
                fifo_w_en   = xfer;
                fifo_w_data = {grant_id_q, req_word[grant_id_q]};

                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                    wr_count_d  = wr_count_q + CNT_W'(1);
                end

                // Release on a dropped valid, on the last allowed beat, or
                // when the fifo is nearly full so others get a turn sooner.
                if (!req_valid[grant_id_q]) begin
                    state_d = IDLE;
                end else if (xfer && ((burst_cnt_q == BC_W'(MAX_BURST - 1)) ||
                                      fifo_almost_full)) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign grant_valid = (state_q == BURST);
    assign grant_id    = grant_id_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Requesters are modelled as word queues;
// a cycle-level model of the arbitration rules predicts every output on each
// falling edge, and literal expectations per scenario pin that model down.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 16;
    localparam int IW = 2;
    localparam int WW = IW + DW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_w_en;
    logic [WW-1:0]    fifo_w_data;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;
    logic [CW-1:0]    wr_count;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_W      (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_w_en        (fifo_w_en),
        .fifo_w_data      (fifo_w_data),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .wr_count         (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i, input int k);
        return 32'hD000_0000 | (32'(i) << 16) | 32'(k);
    endfunction

    // ---------------- requester queues ----------------
    logic [31:0] wbuf [NR][64];
    int          head [NR];
    int          tail [NR];
    int          seqn [NR];
    logic [NR-1:0] acc = '0;

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
            seqn[i] = 0;
        end
    endtask

    task automatic push(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            wbuf[i][tail[i]] = word(i, seqn[i]);
            seqn[i]++;
            tail[i]++;
        end
    endtask

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < NR; i++) if (head[i] < tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (head[i] < tail[i]);
            req_data[i*DW +: DW]  = (head[i] < tail[i]) ? wbuf[i][head[i]] : '0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
        drive();
    endtask

    // ---------------- write log ----------------
    logic [WW-1:0] log_w   [256];
    int            log_cyc [256];
    int            log_n = 0;
    int            cyc_n = 0;

    task automatic clear_log();
        log_n = 0;
    endtask

    // ---------------- behavioural model ----------------
    // Model state: whether a grant is held, by whom, who won last, beats so
    // far in this grant, and total words written.
    bit m_busy = 0, n_busy = 0;
    int m_gid = 0, n_gid = 0;
    int m_last = NR - 1, n_last = NR - 1;
    int m_beats = 0, n_beats = 0;
    int m_count = 0, n_count = 0;

    logic [NR-1:0] e_ready;
    logic          e_wen;
    logic [WW-1:0] e_wdata;
    logic          e_gv;
    logic [IW-1:0] e_gid;
    logic [CW-1:0] e_cnt;
    int            cand;

    always @(negedge clk) begin
        e_ready = '0;
        e_wen   = 1'b0;
        e_wdata = '0;
        e_gv    = 1'b0;
        e_gid   = '0;
        e_cnt   = '0;
        if (!rst_n) begin
            n_busy  = 0;
            n_gid   = 0;
            n_last  = NR - 1;
            n_beats = 0;
            n_count = 0;
        end else begin
            n_busy  = m_busy;
            n_gid   = m_gid;
            n_last  = m_last;
            n_beats = m_beats;
            n_count = m_count;
            e_gv    = m_busy;
            e_gid   = IW'(m_gid);
            e_cnt   = CW'(m_count);
            if (m_busy) begin
                if (!fifo_full) e_ready[m_gid] = 1'b1;
                e_wen   = req_valid[m_gid] && !fifo_full;
                e_wdata = {IW'(m_gid), req_data[m_gid*DW +: DW]};
                if (e_wen) begin
                    n_beats = m_beats + 1;
                    n_count = (m_count + 1) % (1 << CW);
                end
                if (!req_valid[m_gid] || (e_wen && (n_beats == MB || fifo_almost_full)))
                    n_busy = 0;
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    cand = (m_last + k) % NR;
                    if (!n_busy && req_valid[cand]) begin
                        n_busy  = 1;
                        n_gid   = cand;
                        n_last  = cand;
                        n_beats = 0;
                    end
                end
            end
        end
        check("mdl_req_ready",   64'(req_ready),   64'(e_ready));
        check("mdl_fifo_w_en",   64'(fifo_w_en),   64'(e_wen));
        check("mdl_fifo_w_data", 64'(fifo_w_data), 64'(e_wdata));
        check("mdl_grant_valid", 64'(grant_valid), 64'(e_gv));
        check("mdl_grant_id",    64'(grant_id),    64'(e_gid));
        check("mdl_wr_count",    64'(wr_count),    64'(e_cnt));

        acc = req_valid & req_ready;
        if (fifo_w_en && log_n < 256) begin
            log_w[log_n]   = fifo_w_data;
            log_cyc[log_n] = cyc_n;
            log_n++;
        end
    end

    always @(posedge clk) begin
        m_busy  = n_busy;
        m_gid   = n_gid;
        m_last  = n_last;
        m_beats = n_beats;
        m_count = n_count;
        cyc_n++;
    end

    // ---------------- helpers ----------------
    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((pending() || grant_valid) && n < max) begin
            cyc();
            n++;
        end
        check({name, "_drain_timeout"}, 64'(n < max), 64'd1);
    endtask

    task automatic wait_writes(input string name, input int cnt, input int max);
        int n;
        n = 0;
        while (log_n < cnt && n < max) begin
            cyc();
            n++;
        end
        check({name, "_write_timeout"}, 64'(n < max), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic int log_id(input int b);
        return int'(log_w[b][WW-1:DW]);
    endfunction

    function automatic logic [31:0] log_data(input int b);
        return log_w[b][DW-1:0];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n            = 1'b0;
        req_valid        = '0;
        req_data         = '0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        clear_reqs();
        cyc();
        cyc();
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_wr_count",    64'(wr_count),    64'd0);
        check("rst_w_en",        64'(fifo_w_en),   64'd0);
        rst_n = 1'b1;

        // 1: single requester, 6 words -> bursts of 4 and 2 with a bubble
        clear_log();
        push(2, 6);
        drive();
        drain("t1", 60);
        check("t1_nwrites", 64'(log_n), 64'd6);
        for (int b = 0; b < 6; b++) begin
            check("t1_id",   64'(log_id(b)),   64'd2);
            check("t1_data", 64'(log_data(b)), 64'(word(2, b)));
        end
        check("t1_wr_count",    64'(wr_count), 64'd6);
        check("t1_burst1_span", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
        check("t1_bubble",      64'(log_cyc[4] - log_cyc[3]), 64'd2);
        check("t1_burst2_span", 64'(log_cyc[5] - log_cyc[4]), 64'd1);

        // 2: all four requesters continuously valid -> rotation 0,1,2,3,0,...
        do_reset();
        clear_reqs();
        clear_log();
        for (int i = 0; i < NR; i++) push(i, 8);
        drive();
        drain("t2", 200);
        check("t2_nwrites", 64'(log_n), 64'd32);
        for (int b = 0; b < 32; b++) begin
            check("t2_id",   64'(log_id(b)),   64'((b / 4) % 4));
            check("t2_data", 64'(log_data(b)), 64'(word((b / 4) % 4, (b / 16) * 4 + b % 4)));
        end
        check("t2_wr_count", 64'(wr_count), 64'd32);

        // 3: fifo_full for 5 cycles in the middle of requester 1's burst
        do_reset();
        clear_reqs();
        clear_log();
        push(1, 4);
        drive();
        wait_writes("t3", 2, 20);
        fifo_full = 1'b1;
        @(negedge clk);
        #1;
        check("t3_full_w_en",  64'(fifo_w_en),   64'd0);
        check("t3_full_ready", 64'(req_ready),   64'd0);
        check("t3_full_gid",   64'(grant_id),    64'd1);
        check("t3_full_gv",    64'(grant_valid), 64'd1);
        repeat (5) cyc();
        check("t3_held_nwrites", 64'(log_n), 64'd2);
        fifo_full = 1'b0;
        drain("t3", 40);
        check("t3_nwrites", 64'(log_n), 64'd4);
        for (int b = 0; b < 4; b++) begin
            check("t3_id",   64'(log_id(b)),   64'd1);
            check("t3_data", 64'(log_data(b)), 64'(word(1, b)));
        end
        check("t3_resume_gap", 64'(log_cyc[2] - log_cyc[1]), 64'd6);
        check("t3_wr_count",   64'(wr_count), 64'd4);

        // 4: almost_full -> one beat per grant, ids alternate 0,3,0,3
        do_reset();
        clear_reqs();
        clear_log();
        fifo_almost_full = 1'b1;
        push(0, 2);
        push(3, 2);
        drive();
        drain("t4", 40);
        check("t4_nwrites", 64'(log_n), 64'd4);
        check("t4_id0", 64'(log_id(0)), 64'd0);
        check("t4_id1", 64'(log_id(1)), 64'd3);
        check("t4_id2", 64'(log_id(2)), 64'd0);
        check("t4_id3", 64'(log_id(3)), 64'd3);
        check("t4_wr_count", 64'(wr_count), 64'd4);
        fifo_almost_full = 1'b0;

        // 5: requester 1 drops valid after 2 beats; next grant goes to 3
        clear_reqs();
        clear_log();
        push(1, 2);
        drive();
        n = 0;
        while (!(grant_valid && grant_id == 2'd1) && n < 10) begin
            cyc();
            n++;
        end
        check("t5_grant_timeout", 64'(n < 10), 64'd1);
        push(0, 1);
        push(3, 1);
        drive();
        drain("t5", 40);
        check("t5_nwrites", 64'(log_n), 64'd4);
        check("t5_id0", 64'(log_id(0)), 64'd1);
        check("t5_id1", 64'(log_id(1)), 64'd1);
        check("t5_id2", 64'(log_id(2)), 64'd3);
        check("t5_id3", 64'(log_id(3)), 64'd0);
        check("t5_gap",      64'(log_cyc[2] - log_cyc[1]), 64'd3);
        check("t5_wr_count", 64'(wr_count), 64'd8);

        // 6: reset in the middle of requester 3's burst
        do_reset();
        clear_reqs();
        clear_log();
        push(3, 4);
        drive();
        wait_writes("t6", 2, 20);
        check("t6_pre_gid", 64'(grant_id), 64'd3);
        rst_n = 1'b0;
        push(0, 2);
        push(1, 2);
        push(2, 2);
        drive();
        #1;
        check("t6_rst_gv",    64'(grant_valid), 64'd0);
        check("t6_rst_w_en",  64'(fifo_w_en),   64'd0);
        check("t6_rst_ready", 64'(req_ready),   64'd0);
        check("t6_rst_wdata", 64'(fifo_w_data), 64'd0);
        check("t6_rst_gid",   64'(grant_id),    64'd0);
        check("t6_rst_count", 64'(wr_count),    64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        clear_log();
        wait_writes("t6_post", 1, 20);
        check("t6_first_id",    64'(log_id(0)), 64'd0);
        check("t6_first_count", 64'(wr_count),  64'd1);
        drain("t6", 80);
        check("t6_nwrites",  64'(log_n),    64'd8);
        check("t6_wr_count", 64'(wr_count), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
